hbridge_drive: RTL and testbench

- Dual-channel H-bridge output stage for an L298-class motor driver.
- Consumes the per-motor direction requests produced by the line-alignment logic ({IN1,IN2} for motor A, {IN3,IN4} for motor B).
- Drives the bridge pins IN1..IN4 and the enable pins ENA/ENB with PWM speed control.
- Enforces a dead interval on every forward/reverse reversal so the motor never sees an instantaneous polarity flip.

---
 rtl/hbridge_pkg.sv | 36 +++
 rtl/hbridge_channel.sv | 85 ++++++++
 rtl/hbridge_drive.sv | 78 +++++++
 tb/tb_hbridge_drive.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hbridge_pkg.sv
// Shared request encoding and channel state definitions for the dual H-bridge drive.
package hbridge_pkg;

    localparam logic [1:0] REQ_COAST = 2'b00;
    localparam logic [1:0] REQ_FWD   = 2'b10;
    localparam logic [1:0] REQ_REV   = 2'b01;
    localparam logic [1:0] REQ_BRAKE = 2'b11;

    typedef enum logic [2:0] {
        COAST,
        FWD,
        REV,
        BRAKE,
        DEAD
    } chan_state_t;

    // Direction pin pattern {INx, INy} shown while in a given state.
    function automatic logic [1:0] state_pins(input chan_state_t s);
        case (s)
            FWD:     return 2'b10;
            REV:     return 2'b01;
            BRAKE:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic chan_state_t req_to_state(input logic [1:0] r);
        case (r)
            REQ_FWD:   return FWD;
            REQ_REV:   return REV;
            REQ_BRAKE: return BRAKE;
            default:   return COAST;
        endcase
    endfunction

endpackage

// File: rtl/hbridge_channel.sv
// One bridge channel: direction FSM with reversal dead interval, duty latch and registered pins.
module hbridge_channel
    import hbridge_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int DEAD_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [PWM_BITS-1:0] cnt_next,
    input  logic                wrap,
    output logic                in_hi,
    output logic                in_lo,
    output logic                en,
    output logic                busy
);

    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);

    chan_state_t         state_reg, state_next;
    chan_state_t         tgt_reg, tgt_next;
    logic [DW-1:0]       dead_reg, dead_next;
    logic [PWM_BITS-1:0] duty_q_reg, duty_q_next;
    logic                pwm_next;

    // Pins are registered from the next state, so the PWM compare uses the
    // values the counter and duty latch take on the same edge.
    always_comb begin
        duty_q_next = wrap ? duty : duty_q_reg;
        pwm_next    = (cnt_next < duty_q_next);
    end

    always_comb begin
        state_next = state_reg;
        tgt_next   = tgt_reg;
        dead_next  = dead_reg;
        if (req == REQ_COAST) begin
            state_next = COAST;
            dead_next  = '0;
        end else if (state_reg == DEAD) begin
            // Target follows the request; the interval runs out regardless.
            tgt_next = req_to_state(req);
            if (dead_reg == '0) begin
                state_next = tgt_next;
            end else begin
                dead_next = dead_reg - DW'(1);
            end
        end else if (req == REQ_BRAKE) begin
            state_next = BRAKE;
        end else if ((state_reg == FWD && req == REQ_REV) ||
                     (state_reg == REV && req == REQ_FWD)) begin
            state_next = DEAD;
            tgt_next   = req_to_state(req);
            dead_next  = DEAD_LOAD;
        end else begin
            state_next = req_to_state(req);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= COAST;
            tgt_reg    <= COAST;
            dead_reg   <= '0;
            duty_q_reg <= '0;
            in_hi      <= 1'b0;
            in_lo      <= 1'b0;
            en         <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            tgt_reg          <= tgt_next;
            dead_reg         <= dead_next;
            duty_q_reg       <= duty_q_next;
            {in_hi, in_lo}   <= state_pins(state_next);
            en               <= (state_next == BRAKE) ||
                                (((state_next == FWD) || (state_next == REV)) && pwm_next);
            busy             <= (state_next == DEAD);
        end
    end

endmodule

// File: rtl/hbridge_drive.sv
// Dual-channel L298-style output stage: request register, shared PWM counter, two channels.
module hbridge_drive
    import hbridge_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int DEAD_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_a,
    input  logic [1:0]          req_b,
    input  logic [PWM_BITS-1:0] duty_a,
    input  logic [PWM_BITS-1:0] duty_b,
    output logic                IN1,
    output logic                IN2,
    output logic                IN3,
    output logic                IN4,
    output logic                ENA,
    output logic                ENB,
    output logic                busy_a,
    output logic                busy_b
);

    logic [3:0]          req_q_reg;
    logic [PWM_BITS-1:0] cnt_reg, cnt_next;
    logic                wrap;
    logic [PWM_BITS-1:0] duty_in [2];
    logic                hi_w [2];
    logic                lo_w [2];
    logic                en_w [2];
    logic                busy_w [2];

    assign cnt_next   = cnt_reg + PWM_BITS'(1);
    // Strobe on the edge where the counter rolls over to 0.
    assign wrap       = &cnt_reg;
    assign duty_in[0] = duty_a;
    assign duty_in[1] = duty_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            req_q_reg <= {req_b, req_a};
            cnt_reg   <= cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            hbridge_channel #(
                .PWM_BITS    (PWM_BITS),
                .DEAD_CYCLES (DEAD_CYCLES)
            ) u_chan (
                .clk      (clk),
                .rst      (rst),
                .req      (req_q_reg[2*gi +: 2]),
                .duty     (duty_in[gi]),
                .cnt_next (cnt_next),
                .wrap     (wrap),
                .in_hi    (hi_w[gi]),
                .in_lo    (lo_w[gi]),
                .en       (en_w[gi]),
                .busy     (busy_w[gi])
            );
        end
    endgenerate

    assign IN1    = hi_w[0];
    assign IN2    = lo_w[0];
    assign ENA    = en_w[0];
    assign busy_a = busy_w[0];
    assign IN3    = hi_w[1];
    assign IN4    = lo_w[1];
    assign ENB    = en_w[1];
    assign busy_b = busy_w[1];

endmodule

// File: tb/tb_hbridge_drive.sv
// Scenario bench for hbridge_drive with a cycle-level reference model feeding a scoreboard.
module tb_hbridge_drive;

    localparam int PW  = 4;
    localparam int DC  = 4;
    localparam int PER = 1 << PW;
    localparam int S_CO = 0, S_FW = 1, S_RV = 2, S_BR = 3, S_DD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_a, req_b;
    logic [PW-1:0] duty_a, duty_b;
    logic          IN1, IN2, IN3, IN4, ENA, ENB, busy_a, busy_b;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] sb_q [$];
    logic [7:0] g, x;

    int         m_cnt;
    int         m_dq   [2];
    logic [1:0] m_rq   [2];
    int         m_st   [2];
    int         m_tgt  [2];
    int         m_left [2];

    always #5 clk = ~clk;

    hbridge_drive #(
        .PWM_BITS    (PW),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_a  (req_a),
        .req_b  (req_b),
        .duty_a (duty_a),
        .duty_b (duty_b),
        .IN1    (IN1),
        .IN2    (IN2),
        .IN3    (IN3),
        .IN4    (IN4),
        .ENA    (ENA),
        .ENB    (ENB),
        .busy_a (busy_a),
        .busy_b (busy_b)
    );

    function automatic logic [7:0] obs();
        return {IN1, IN2, ENA, busy_a, IN3, IN4, ENB, busy_b};
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        for (int c = 0; c < 2; c++) begin
            m_dq[c] = 0; m_rq[c] = 2'b00; m_st[c] = S_CO; m_tgt[c] = S_CO; m_left[c] = 0;
        end
    endtask

    // Predict the pins after the coming edge, queue the prediction, then advance.
    task automatic step();
        logic [1:0] rin [2];
        int         din [2];
        int         ncnt;
        logic [7:0] e;
        logic [1:0] r, p;
        logic       en, bz;
        rin[0] = req_a;  rin[1] = req_b;
        din[0] = duty_a; din[1] = duty_b;
        ncnt = (m_cnt + 1) % PER;
        e = '0;
        for (int c = 0; c < 2; c++) begin
            if (m_cnt == PER - 1) m_dq[c] = din[c];
            r = m_rq[c];
            if (r == 2'b00) m_st[c] = S_CO;
            else if (m_st[c] == S_DD) begin
                m_tgt[c] = (r == 2'b11) ? S_BR : (r == 2'b10) ? S_FW : S_RV;
                m_left[c]--;
                if (m_left[c] == 0) m_st[c] = m_tgt[c];
            end else if (r == 2'b11) m_st[c] = S_BR;
            else if ((m_st[c] == S_FW && r == 2'b01) || (m_st[c] == S_RV && r == 2'b10)) begin
                m_st[c] = S_DD; m_left[c] = DC;
            end else m_st[c] = (r == 2'b10) ? S_FW : S_RV;
            m_rq[c] = rin[c];
            case (m_st[c])
                S_FW:    begin p = 2'b10; en = (ncnt < m_dq[c]); bz = 1'b0; end
                S_RV:    begin p = 2'b01; en = (ncnt < m_dq[c]); bz = 1'b0; end
                S_BR:    begin p = 2'b11; en = 1'b1; bz = 1'b0; end
                S_DD:    begin p = 2'b00; en = 1'b0; bz = 1'b1; end
                default: begin p = 2'b00; en = 1'b0; bz = 1'b0; end
            endcase
            e[7-4*c -: 4] = {p, en, bz};
        end
        m_cnt = ncnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_a = 2'b00; req_b = 2'b00; duty_a = '0; duty_b = '0;
        repeat (3) @(posedge clk);
        #1;
        g = obs(); n_assert++;
        if (g !== 8'h00) begin n_fail++; $display("FAIL reset_hold got %b want 00000000", g); end
        else $display("ok   reset_hold pins %b", g);
        rst = 1'b0;
        model_reset();
        repeat (3) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_reset t=%0t got %b want %b", $time, g, x); end
            else $display("ok   sb_reset t=%0t pins %b", $time, g);
        end
    endtask

    task automatic test_fwd_pwm();
        int hi;
        req_a = 2'b10; duty_a = 4'd8;
        step();
        g = obs(); x = sb_q.pop_front(); n_assert++;
        if (g !== x) begin n_fail++; $display("FAIL sb_fwd t=%0t got %b want %b", $time, g, x); end
        n_assert++;
        if ({IN1, IN2} !== 2'b00) begin n_fail++; $display("FAIL fwd_latency1 got %b want 00", {IN1, IN2}); end
        else $display("ok   fwd_latency1 IN1/IN2 %b", {IN1, IN2});
        step();
        g = obs(); x = sb_q.pop_front(); n_assert++;
        if (g !== x) begin n_fail++; $display("FAIL sb_fwd t=%0t got %b want %b", $time, g, x); end
        n_assert++;
        if ({IN1, IN2} !== 2'b10) begin n_fail++; $display("FAIL fwd_latency2 got %b want 10", {IN1, IN2}); end
        else $display("ok   fwd_latency2 IN1/IN2 %b", {IN1, IN2});
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_fwd_pwm t=%0t got %b want %b", $time, g, x); end
            else $display("ok   sb_fwd_pwm t=%0t pins %b", $time, g);
            if (i >= 24) hi += int'(ENA);
        end
        n_assert++;
        if (hi !== 8) begin n_fail++; $display("FAIL fwd_pwm_duty ENA high %0d of 16, want 8", hi); end
        else $display("ok   fwd_pwm_duty ENA high %0d of 16", hi);
    endtask

    task automatic test_reversal();
        int n;
        req_a = 2'b01;
        repeat (2) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_rev t=%0t got %b want %b", $time, g, x); end
        end
        n = 0;
        while (busy_a && n < 10) begin
            n++;
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_rev_dead t=%0t got %b want %b", $time, g, x); end
            else $display("ok   sb_rev_dead t=%0t pins %b", $time, g);
        end
        n_assert++;
        if (n !== DC) begin n_fail++; $display("FAIL rev_dead_len got %0d cycles want %0d", n, DC); end
        else $display("ok   rev_dead_len %0d cycles", n);
        n_assert++;
        if ({IN1, IN2, busy_a} !== 3'b010) begin n_fail++; $display("FAIL rev_dir got %b want 010", {IN1, IN2, busy_a}); end
        else $display("ok   rev_dir IN1/IN2/busy %b", {IN1, IN2, busy_a});
    endtask

    task automatic test_dead_toggle();
        int n, bz;
        req_a = 2'b10;
        repeat (2) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_toggle t=%0t got %b want %b", $time, g, x); end
        end
        n = 0;
        while (busy_a && n < 10) begin
            req_a = (n == 0) ? 2'b01 : 2'b10;
            n++;
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_toggle_dead t=%0t got %b want %b", $time, g, x); end
            else $display("ok   sb_toggle_dead t=%0t pins %b", $time, g);
        end
        n_assert++;
        if (n !== DC) begin n_fail++; $display("FAIL toggle_dead_len got %0d cycles want %0d", n, DC); end
        else $display("ok   toggle_dead_len %0d cycles", n);
        bz = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_toggle_fwd t=%0t got %b want %b", $time, g, x); end
            bz += int'(busy_a);
        end
        n_assert++;
        if (bz !== 0 || {IN1, IN2} !== 2'b10) begin
            n_fail++; $display("FAIL toggle_no_redead busy cycles %0d IN %b, want 0 and 10", bz, {IN1, IN2});
        end else $display("ok   toggle_no_redead IN1/IN2 %b", {IN1, IN2});
    endtask

    task automatic test_dead_abort();
        req_a = 2'b01;
        repeat (2) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_abort t=%0t got %b want %b", $time, g, x); end
        end
        n_assert++;
        if (busy_a !== 1'b1) begin n_fail++; $display("FAIL abort_enter busy_a %b want 1", busy_a); end
        else $display("ok   abort_enter busy_a %b", busy_a);
        req_a = 2'b00;
        repeat (2) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_abort t=%0t got %b want %b", $time, g, x); end
        end
        n_assert++;
        if ({IN1, IN2, ENA, busy_a} !== 4'b0000) begin
            n_fail++; $display("FAIL abort_coast got %b want 0000", {IN1, IN2, ENA, busy_a});
        end else $display("ok   abort_coast pins %b", {IN1, IN2, ENA, busy_a});
        req_a = 2'b10;
        repeat (2) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_abort t=%0t got %b want %b", $time, g, x); end
        end
        n_assert++;
        if ({IN1, IN2, busy_a} !== 3'b100) begin n_fail++; $display("FAIL abort_fwd_now got %b want 100", {IN1, IN2, busy_a}); end
        else $display("ok   abort_fwd_now IN1/IN2/busy %b", {IN1, IN2, busy_a});
    endtask

    task automatic test_brake_duty();
        int hi;
        req_b = 2'b11; duty_b = '0;
        repeat (2) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_brake t=%0t got %b want %b", $time, g, x); end
        end
        n_assert++;
        if ({IN3, IN4, ENB} !== 3'b111) begin n_fail++; $display("FAIL brake_pins got %b want 111", {IN3, IN4, ENB}); end
        else $display("ok   brake_pins IN3/IN4/ENB %b", {IN3, IN4, ENB});
        hi = 0;
        for (int i = 0; i < PER; i++) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_brake t=%0t got %b want %b", $time, g, x); end
            hi += int'(ENB);
        end
        n_assert++;
        if (hi !== PER) begin n_fail++; $display("FAIL brake_en_const ENB high %0d want %0d", hi, PER); end
        else $display("ok   brake_en_const ENB high %0d", hi);
        req_b = 2'b10;
        for (int i = 0; i < 2 || (i < 24 && m_cnt != 5); i++) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_duty t=%0t got %b want %b", $time, g, x); end
        end
        duty_b = 4'd12;
        hi = 0;
        for (int i = 0; i < 2 * PER; i++) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_duty t=%0t got %b want %b", $time, g, x); end
            else $display("ok   sb_duty t=%0t pins %b", $time, g);
            if (m_cnt == 0) break;
            hi += int'(ENB);
        end
        n_assert++;
        if (hi !== 0) begin n_fail++; $display("FAIL duty_mid_period ENB high %0d before wrap, want 0", hi); end
        else $display("ok   duty_mid_period ENB held low until wrap");
        hi = int'(ENB);
        for (int i = 0; i < PER - 1; i++) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_duty t=%0t got %b want %b", $time, g, x); end
            hi += int'(ENB);
        end
        n_assert++;
        if (hi !== 12) begin n_fail++; $display("FAIL duty_next_period ENB high %0d want 12", hi); end
        else $display("ok   duty_next_period ENB high %0d", hi);
    endtask

    task automatic test_reset_dead();
        req_a = 2'b01; req_b = 2'b01;
        repeat (2) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_both t=%0t got %b want %b", $time, g, x); end
        end
        n_assert++;
        if ({busy_a, busy_b} !== 2'b11) begin n_fail++; $display("FAIL both_dead busy %b want 11", {busy_a, busy_b}); end
        else $display("ok   both_dead busy %b", {busy_a, busy_b});
        step();
        g = obs(); x = sb_q.pop_front(); n_assert++;
        if (g !== x) begin n_fail++; $display("FAIL sb_both t=%0t got %b want %b", $time, g, x); end
        #2;
        rst = 1'b1;
        #1;
        g = obs(); n_assert++;
        if (g !== 8'h00) begin n_fail++; $display("FAIL async_reset got %b want 00000000", g); end
        else $display("ok   async_reset pins %b", g);
        model_reset();
        req_a = 2'b10; req_b = 2'b10;
        @(posedge clk);
        #1;
        g = obs(); n_assert++;
        if (g !== 8'h00) begin n_fail++; $display("FAIL reset_held got %b want 00000000", g); end
        else $display("ok   reset_held pins %b", g);
        rst = 1'b0;
        repeat (2) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_post_reset t=%0t got %b want %b", $time, g, x); end
        end
        n_assert++;
        if ({IN1, IN2, busy_a, IN3, IN4, busy_b} !== 6'b100100) begin
            n_fail++; $display("FAIL post_reset_fwd got %b want 100100", {IN1, IN2, busy_a, IN3, IN4, busy_b});
        end else $display("ok   post_reset_fwd pins %b", {IN1, IN2, busy_a, IN3, IN4, busy_b});
        repeat (6) begin
            step();
            g = obs(); x = sb_q.pop_front(); n_assert++;
            if (g !== x) begin n_fail++; $display("FAIL sb_post_reset t=%0t got %b want %b", $time, g, x); end
            else $display("ok   sb_post_reset t=%0t pins %b", $time, g);
        end
    endtask

    initial begin
        test_reset();
        test_fwd_pwm();
        test_reversal();
        test_dead_toggle();
        test_dead_abort();
        test_brake_duty();
        test_reset_dead();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
